// File: rtl/lsu_mem_pkg.sv
// Shared types and default widths for the LSU memory responder.
// Used by lsu_mem_array and lsu_mem_responder.
package lsu_mem_pkg;

  localparam int LSU_INDEX_W = 19;
  localparam int LSU_DATA_W  = 64;

  typedef enum logic {
    CH_LOAD,
    CH_STORE
  } ch_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } st_e;

endpackage

// File: rtl/lsu_mem_array.sv
// Single-port word array with bit-masked write and registered read.
// Read register holds its value until the next enabled read.
module lsu_mem_array
  import lsu_mem_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = LSU_DATA_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] wmask,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (en && we)
      mem[addr] <= (mem[addr] & ~wmask)
                 | (wdata & wmask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rdata <= '0;
    else if (en && !we)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Round-robin load/store responder over a word array.
// LSU_MEM_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-driven cycles per request.
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int INDEX_W    = LSU_INDEX_W,
  parameter int DATA_W     = LSU_DATA_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               opload_index_valid,
  input  logic [INDEX_W-1:0] opload_index,
  output logic               opload_index_ready,
  output logic [DATA_W-1:0]  opload_read_data,
  output logic               opload_operation_done,
  input  logic               opstore_index_valid,
  input  logic [INDEX_W-1:0] opstore_index,
  input  logic [DATA_W-1:0]  opstore_write_data,
  input  logic [DATA_W-1:0]  opstore_write_mask,
  output logic               opstore_index_ready,
  output logic               opstore_operation_done
);

  localparam int CNT_W = $clog2(LATENCY + 4) + 1;
  localparam int AW    = DEPTH_LOG2;

  st_e              state_q, state_d;
  ch_e              last_grant_q, ch_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q;
  logic [DATA_W-1:0] wdata_q, wmask_q;

  logic [1:0]       extra;
  logic [CNT_W-1:0] eff_lat;
  logic             fast;
  logic             idle;
  logic             grant_ld, grant_st;
  logic             hs_ld, hs_st, hs;
  logic             done_now;
  logic [AW-1:0]    addr_in;

  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wmask;

  logic             unused_idx;
  assign unused_idx = ^{opload_index[INDEX_W-1:AW],
                        opstore_index[INDEX_W-1:AW]};

`ifdef LSU_MEM_RESP_RANDOM_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      lfsr_q <= 8'hA5;
    else
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5]
               ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(extra);
  assign fast    = (eff_lat == CNT_W'(1));

  // Ties go to whichever channel lost the previous handshake.
  assign grant_ld = opload_index_valid
                 && (!opstore_index_valid
                  || last_grant_q == CH_STORE);
  assign grant_st = opstore_index_valid
                 && (!opload_index_valid
                  || last_grant_q == CH_LOAD);

  assign idle = (state_q == ST_IDLE) && !reset;

  assign opload_index_ready  = idle && grant_ld;
  assign opstore_index_ready = idle && grant_st;

  assign hs_ld = opload_index_ready;
  assign hs_st = opstore_index_ready;
  assign hs    = hs_ld || hs_st;

  assign addr_in = hs_st ? opstore_index[AW-1:0]
                         : opload_index[AW-1:0];

  assign done_now = (state_q == ST_BUSY)
                 && (cnt_q == '0);

  // Single-cycle requests access the array straight off the handshake.
  assign mem_en    = !reset && (done_now || (hs && fast));
  assign mem_we    = done_now ? (ch_q == CH_STORE) : hs_st;
  assign mem_addr  = done_now ? idx_q   : addr_in;
  assign mem_wdata = done_now ? wdata_q : opstore_write_data;
  assign mem_wmask = done_now ? wmask_q : opstore_write_mask;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs && !fast) begin
          state_d = ST_BUSY;
          cnt_d   = eff_lat - CNT_W'(2);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                <= ST_IDLE;
      cnt_q                  <= '0;
      last_grant_q           <= CH_STORE;
      ch_q                   <= CH_LOAD;
      idx_q                  <= '0;
      wdata_q                <= '0;
      wmask_q                <= '0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      opload_operation_done  <= mem_en && !mem_we;
      opstore_operation_done <= mem_en && mem_we;
      if (hs) begin
        last_grant_q <= hs_st ? CH_STORE : CH_LOAD;
        ch_q         <= hs_st ? CH_STORE : CH_LOAD;
        idx_q        <= addr_in;
        wdata_q      <= opstore_write_data;
        wmask_q      <= opstore_write_mask;
      end
    end
  end

  lsu_mem_array #(
    .AW (AW),
    .DW (DATA_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .wmask (mem_wmask),
    .rdata (opload_read_data)
  );

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder (LATENCY=2 and LATENCY=1).
// Reference memory is an associative array updated at store completion.
module tb_lsu_mem_responder;

  localparam int IW   = 19;
  localparam int DW   = 64;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;
`ifdef LSU_MEM_RESP_RANDOM_DELAY_EN
  localparam int XTRA = 3;
`else
  localparam int XTRA = 0;
`endif

  typedef struct {
    bit            is_ld;
    bit            known;
    logic [DW-1:0] data;
    logic [DW-1:0] wd;
    logic [DW-1:0] wm;
    int            key;
    int            cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int fails  = 0;

  logic          ld_v = 1'b0, st_v = 1'b0;
  logic [IW-1:0] ld_idx = '0, st_idx = '0;
  logic [DW-1:0] st_d = '0, st_m = '0;
  logic          ld_rdy, st_rdy, ld_done, st_done;
  logic [DW-1:0] ld_rd;

  logic          l1_v = 1'b0, s1_v = 1'b0;
  logic [IW-1:0] l1_idx = '0, s1_idx = '0;
  logic [DW-1:0] s1_d = '0, s1_m = '0;
  logic          l1_rdy, s1_rdy, l1_done, s1_done;
  logic [DW-1:0] l1_rd;

  lsu_mem_responder #(
    .INDEX_W (IW), .DATA_W (DW),
    .DEPTH_LOG2 (12), .LATENCY (LAT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .opload_index_valid     (ld_v),
    .opload_index           (ld_idx),
    .opload_index_ready     (ld_rdy),
    .opload_read_data       (ld_rd),
    .opload_operation_done  (ld_done),
    .opstore_index_valid    (st_v),
    .opstore_index          (st_idx),
    .opstore_write_data     (st_d),
    .opstore_write_mask     (st_m),
    .opstore_index_ready    (st_rdy),
    .opstore_operation_done (st_done)
  );

  lsu_mem_responder #(
    .INDEX_W (IW), .DATA_W (DW),
    .DEPTH_LOG2 (12), .LATENCY (LAT1)
  ) dut1 (
    .clock                  (clock),
    .reset                  (reset),
    .opload_index_valid     (l1_v),
    .opload_index           (l1_idx),
    .opload_index_ready     (l1_rdy),
    .opload_read_data       (l1_rd),
    .opload_operation_done  (l1_done),
    .opstore_index_valid    (s1_v),
    .opstore_index          (s1_idx),
    .opstore_write_data     (s1_d),
    .opstore_write_mask     (s1_m),
    .opstore_index_ready    (s1_rdy),
    .opstore_operation_done (s1_done)
  );

  exp_t          q[$];
  exp_t          q1[$];
  logic [DW-1:0] mdl[int];
  logic [DW-1:0] mdl1[int];
  bit            last_ld = 1'b0;
  bit            grants[$];

  always @(negedge clock) begin
    exp_t e;
    bit   exp_lr, exp_sr;
    int   lat;
    if (reset) begin
      q.delete();
      last_ld = 1'b0;
    end else begin
      if (ld_done || st_done) begin
        checks++;
        if (q.size() == 0 || (ld_done && st_done)) begin
          fails++;
          $display("FAIL done_spurious ld=%0b st=%0b outstanding=%0d want one done per request",
                   ld_done, st_done, q.size());
        end else begin
          e = q.pop_front();
          checks++;
          if (ld_done != e.is_ld) begin
            fails++;
            $display("FAIL done_channel got load=%0b want load=%0b",
                     ld_done, e.is_ld);
          end
          lat = cyc - e.cyc;
          checks++;
          if (lat < LAT || lat > LAT + XTRA) begin
            fails++;
            $display("FAIL latency got %0d want %0d..%0d",
                     lat, LAT, LAT + XTRA);
          end
          if (e.is_ld && e.known) begin
            checks++;
            if (ld_rd !== e.data) begin
              fails++;
              $display("FAIL load_data idx=%0d got %h want %h",
                       e.key, ld_rd, e.data);
            end
          end
          if (!e.is_ld) begin
            if (mdl.exists(e.key))
              mdl[e.key] = (mdl[e.key] & ~e.wm) | (e.wd & e.wm);
            else if (e.wm == '1)
              mdl[e.key] = e.wd;
          end
        end
      end
      exp_lr = 1'b0;
      exp_sr = 1'b0;
      if (q.size() == 0) begin
        exp_lr = ld_v && (!st_v || !last_ld);
        exp_sr = st_v && (!ld_v || last_ld);
      end
      checks++;
      if (ld_rdy !== exp_lr || st_rdy !== exp_sr) begin
        fails++;
        $display("FAIL ready got ld=%0b st=%0b want ld=%0b st=%0b",
                 ld_rdy, st_rdy, exp_lr, exp_sr);
      end
      if ((ld_v && ld_rdy) || (st_v && st_rdy)) begin
        e.is_ld = ld_v && ld_rdy;
        e.key   = e.is_ld ? int'(ld_idx[11:0]) : int'(st_idx[11:0]);
        e.known = 1'b0;
        e.data  = '0;
        if (e.is_ld && mdl.exists(e.key)) begin
          e.known = 1'b1;
          e.data  = mdl[e.key];
        end
        e.wd    = st_d;
        e.wm    = st_m;
        e.cyc   = cyc;
        last_ld = e.is_ld;
        grants.push_back(e.is_ld);
        q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    int   lat;
    if (reset) begin
      q1.delete();
    end else begin
      if (l1_done || s1_done) begin
        checks++;
        if (q1.size() == 0 || (l1_done && s1_done)) begin
          fails++;
          $display("FAIL l1_done_spurious ld=%0b st=%0b want one done per request",
                   l1_done, s1_done);
        end else begin
          e = q1.pop_front();
          lat = cyc - e.cyc;
          checks++;
          if (lat < LAT1 || lat > LAT1 + XTRA || l1_done != e.is_ld) begin
            fails++;
            $display("FAIL l1_done got lat=%0d load=%0b want lat %0d..%0d load=%0b",
                     lat, l1_done, LAT1, LAT1 + XTRA, e.is_ld);
          end
          if (e.is_ld && e.known) begin
            checks++;
            if (l1_rd !== e.data) begin
              fails++;
              $display("FAIL l1_load_data idx=%0d got %h want %h",
                       e.key, l1_rd, e.data);
            end
          end
          if (!e.is_ld && e.wm == '1)
            mdl1[e.key] = e.wd;
        end
      end
      if ((l1_v && l1_rdy) || (s1_v && s1_rdy)) begin
        e.is_ld = l1_v && l1_rdy;
        e.key   = e.is_ld ? int'(l1_idx[11:0]) : int'(s1_idx[11:0]);
        e.known = 1'b0;
        e.data  = '0;
        if (e.is_ld && mdl1.exists(e.key)) begin
          e.known = 1'b1;
          e.data  = mdl1[e.key];
        end
        e.wd  = s1_d;
        e.wm  = s1_m;
        e.cyc = cyc;
        q1.push_back(e);
      end
    end
  end

  task automatic wait_hs(input string nm, input bit is_ld);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(is_ld ? ld_rdy : st_rdy) && n < 64);
    checks++;
    if (!(is_ld ? ld_rdy : st_rdy)) begin
      fails++;
      $display("FAIL %s_timeout ready=0 want 1 within 64 cycles", nm);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_load(input logic [IW-1:0] idx);
    ld_idx = idx;
    ld_v   = 1'b1;
    wait_hs("load_hs", 1'b1);
    ld_v = 1'b0;
  endtask

  task automatic drive_store(input logic [IW-1:0] idx,
                             input logic [DW-1:0] d,
                             input logic [DW-1:0] m);
    st_idx = idx;
    st_d   = d;
    st_m   = m;
    st_v   = 1'b1;
    wait_hs("store_hs", 1'b0);
    st_v = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL idle_timeout outstanding=%0d want 0", q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string nm,
                           input logic [DW-1:0] got,
                           input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_rst(input string nm);
    checks++;
    if (ld_rdy !== 1'b0 || st_rdy !== 1'b0 || ld_done !== 1'b0
        || st_done !== 1'b0 || ld_rd !== '0) begin
      fails++;
      $display("FAIL %s got rdy=%0b%0b done=%0b%0b data=%h want all zero",
               nm, ld_rdy, st_rdy, ld_done, st_done, ld_rd);
    end
  endtask

  initial begin
    int            n;
    int            r;
    int            n0;
    logic [3:0]    g4;
    logic [IW-1:0] idx;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_rst("reset_init");
    @(posedge clock);
    #1 reset = 1'b0;

    drive_store(IW'(5), 64'h1122334455667788, '1);
    ld_idx = IW'(3);
    ld_v   = 1'b1;
    @(posedge clock);
    #1 ld_v = 1'b0;
    wait_idle();
    drive_load(IW'(5));
    wait_idle();
    check_val("load_full", ld_rd, 64'h1122334455667788);

    drive_store(IW'(5), '1, 64'h00000000FFFFFFFF);
    wait_idle();
    drive_load(IW'(5));
    wait_idle();
    check_val("load_masked", ld_rd, 64'h11223344FFFFFFFF);

    drive_store(IW'(9), 64'hAA, '1);
    wait_idle();
    drive_store(IW'(9), 64'h5555, '1);
    reset = 1'b1;
    @(negedge clock);
    chk_rst("reset_mid");
    @(posedge clock);
    @(negedge clock);
    chk_rst("reset_hold");
    @(posedge clock);
    #1 reset = 1'b0;

    grants.delete();
    ld_idx = IW'(9);
    st_idx = IW'(20);
    st_d   = 64'hDEADBEEF00000001;
    st_m   = '1;
    ld_v   = 1'b1;
    st_v   = 1'b1;
    n = 0;
    while (grants.size() < 4 && n < 64) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    ld_v = 1'b0;
    st_v = 1'b0;
    g4 = '0;
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) g4[3-i] = grants[i];
    checks++;
    if (grants.size() != 4 || g4 != 4'b1010) begin
      fails++;
      $display("FAIL arb_order got n=%0d seq=%b want n=4 seq=1010",
               grants.size(), g4);
    end
    wait_idle();
    check_val("load_after_reset", ld_rd, 64'hAA);

    for (int i = 0; i < 16; i++)
      drive_store(IW'(i), {$urandom, $urandom}, '1);
    wait_idle();
    for (int i = 0; i < 200; i++) begin
      r   = $urandom_range(0, 3);
      idx = {7'($urandom), 8'h00, 4'($urandom)};
      case (r)
        0, 1: drive_load(idx);
        2: drive_store(idx, {$urandom, $urandom},
                       {$urandom, $urandom});
        default: begin
          ld_idx = idx;
          st_idx = {7'($urandom), 8'h00, 4'($urandom)};
          st_d   = {$urandom, $urandom};
          st_m   = {$urandom, $urandom};
          ld_v   = 1'b1;
          st_v   = 1'b1;
          n0 = grants.size();
          n  = 0;
          while (grants.size() == n0 && n < 64) begin
            @(negedge clock);
            n++;
          end
          checks++;
          if (grants.size() == n0) begin
            fails++;
            $display("FAIL tie_timeout grants=%0d want %0d", n0, n0 + 1);
          end
          @(posedge clock);
          #1;
          ld_v = 1'b0;
          st_v = 1'b0;
        end
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    wait_idle();

    s1_m = '1;
    s1_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s1_idx = IW'(i);
      s1_d   = {32'hC0DE0000, 32'(i * 7 + 1)};
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!s1_rdy && n < 32);
      checks++;
      if (!s1_rdy) begin
        fails++;
        $display("FAIL l1_store_timeout ready=0 want 1");
      end
`ifndef LSU_MEM_RESP_RANDOM_DELAY_EN
      checks++;
      if (n != 1) begin
        fails++;
        $display("FAIL l1_store_ready_gap got %0d cycles want 1", n);
      end
`endif
      @(posedge clock);
      #1;
    end
    s1_v = 1'b0;
    l1_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l1_idx = IW'(i);
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!l1_rdy && n < 32);
      checks++;
      if (!l1_rdy) begin
        fails++;
        $display("FAIL l1_load_timeout ready=0 want 1");
      end
`ifndef LSU_MEM_RESP_RANDOM_DELAY_EN
      checks++;
      if (n != 1) begin
        fails++;
        $display("FAIL l1_load_ready_gap got %0d cycles want 1", n);
      end
`endif
      @(posedge clock);
      #1;
    end
    l1_v = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 32) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL l1_idle_timeout outstanding=%0d want 0", q1.size());
    end
    check_val("l1_last_load", l1_rd, {32'hC0DE0000, 32'(7 * 7 + 1)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
